// File: rtl/outdev_arbiter_if.sv
// outdev_arbiter_if
// Bundles the two requester ports and the output-device bus of outdev_arbiter.
//   slave  : arbiter side (takes requests and dev_dout, drives grants/done/err/rdata and the device bus)
//   master : requester/device side (drives requests and dev_dout, observes the rest)
// Requester signals: req*, we*, addr*[3:2], wdata*, gnt*, done*, err*, rdata*
// Device signals   : dev_en, dev_addr[3:2], dev_din, dev_dout
interface outdev_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [3:2]  addr0;
    logic [3:2]  addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic        err0;
    logic        err1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        dev_en;
    logic [3:2]  dev_addr;
    logic [31:0] dev_din;
    logic [31:0] dev_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dev_dout,
        output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
               dev_en, dev_addr, dev_din
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dev_dout,
        input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
               dev_en, dev_addr, dev_din
    );
endinterface

// File: rtl/outdev_arbiter.sv
// outdev_arbiter
// Two-master arbiter that serialises single-word read/write transactions onto
// the output device bus (word offsets 0 and 1 are legal, 2 and 3 are rejected).
// Each transaction runs IDLE -> ACC -> DONE, one cycle each, ending in a done pulse.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : outdev_arbiter_if.slave (requester 0 = CPU path, requester 1 = secondary master)
// Configuration:
//   OUTDEV_ARB_RR_EN defined   -> round-robin on ties (requester not granted last wins)
//   OUTDEV_ARB_RR_EN undefined -> fixed priority, requester 0 wins ties
module outdev_arbiter (
    input  logic              clk,
    input  logic              rst_n,
    outdev_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t      state_q;
    state_t      state_d;
    logic        owner_q;
    logic        we_q;
    logic        err_q;
    logic        dev_en_q;
    logic [3:2]  dev_addr_q;
    logic [31:0] dev_din_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    logic        any_req;
    logic        win;
    logic        sel_we;
    logic [3:2]  sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] rd_val;

    assign any_req = bus.req0 | bus.req1;

`ifdef OUTDEV_ARB_RR_EN
    logic last_q;
    // On a tie the requester that was not granted last wins.
    assign win = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
`else
    assign win = ~bus.req0;
`endif

    always_comb begin
        sel_we    = bus.we0;
        sel_addr  = bus.addr0;
        sel_wdata = bus.wdata0;
        if (win) begin
            sel_we    = bus.we1;
            sel_addr  = bus.addr1;
            sel_wdata = bus.wdata1;
        end
    end

    // Addresses 2 and 3 are illegal: they read back as zero.
    assign rd_val = err_q ? '0 : bus.dev_dout;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACC;
            ACC:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            dev_en_q   <= 1'b0;
            dev_addr_q <= '0;
            dev_din_q  <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
`ifdef OUTDEV_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q    <= win;
                        we_q       <= sel_we;
                        err_q      <= sel_addr[3];
                        // Illegal addresses never assert the device write enable.
                        dev_en_q   <= sel_we & ~sel_addr[3];
                        dev_addr_q <= sel_addr;
                        dev_din_q  <= sel_wdata;
`ifdef OUTDEV_ARB_RR_EN
                        last_q     <= win;
`endif
                    end
                end
                ACC: begin
                    dev_en_q <= 1'b0;
                    if (!we_q) begin
                        if (owner_q) rdata1_q <= rd_val;
                        else         rdata0_q <= rd_val;
                    end
                end
                default: dev_en_q <= 1'b0;
            endcase
        end
    end

    assign bus.gnt0     = (state_q != IDLE) & ~owner_q;
    assign bus.gnt1     = (state_q != IDLE) &  owner_q;
    assign bus.done0    = (state_q == DONE) & ~owner_q;
    assign bus.done1    = (state_q == DONE) &  owner_q;
    assign bus.err0     = bus.done0 & err_q;
    assign bus.err1     = bus.done1 & err_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.dev_en   = dev_en_q;
    assign bus.dev_addr = dev_addr_q;
    assign bus.dev_din  = dev_din_q;
endmodule
